// File: rtl/univ_shift_reg_shr.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_shr
//   Parametrised universal shift register with a burst sequencer.
//   Operations: hold, load, shift left/right, rotate left/right,
//   arithmetic shift right and clear. A burst repeats one operation
//   'count' times without further intervention.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active high, highest priority
//   en      single-step enable (ignored while start=1 or busy=1)
//   mode    operation select (0 hold,1 load,2 SHL,3 SHR,4 ROL,5 ROR,6 ASR,7 clear)
//   d       parallel load data
//   sin_l   serial input entering the MSB on SHR
//   sin_r   serial input entering the LSB on SHL
//   start   burst request, sampled only while busy=0
//   count   number of burst operations, sampled with start
//   q       register contents
//   sout_l  q[WIDTH-1]
//   sout_r  q[0]
//   busy    burst in progress
//   done    one-cycle pulse after the last burst operation
// ---------------------------------------------------------------------------
module univ_shift_reg_shr #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNTW-1:0]  count,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state;
   logic [2:0]      op_r;
   logic [CNTW-1:0] rem;

   // Next register value for one application of 'op'.
   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] din,
      input logic             sl,
      input logic             sr
   );
      logic [WIDTH-1:0] nxt;
      case (op)
         3'd0:    nxt = cur;
         3'd1:    nxt = din;
         3'd2:    nxt = {cur[WIDTH-2:0], sr};
         3'd3:    nxt = {sl, cur[WIDTH-1:1]};
         3'd4:    nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
         3'd5:    nxt = {cur[0], cur[WIDTH-1:1]};
         3'd6:    nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
         default: nxt = '0;
      endcase
      return nxt;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         state <= IDLE;
         op_r  <= 3'd0;
         rem   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Burst accepted: latch op and count, q untouched this edge.
                  op_r <= mode;
                  rem  <= count;
                  if (count != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end else if (en) begin
                  q <= apply_op(mode, q, d, sin_l, sin_r);
               end
            end
            RUN: begin
               // Live serial inputs and d are used on every burst step.
               q   <= apply_op(op_r, q, d, sin_l, sin_r);
               rem <= rem - 1'b1;
               if (rem == {{(CNTW-1){1'b0}}, 1'b1}) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg_shr.sv
module tb_univ_shift_reg_shr;

   localparam int W    = 8;
   localparam int CNTW = $clog2(W + 1);

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            en = 1'b0;
   logic [2:0]      mode = 3'd0;
   logic [W-1:0]    d = '0;
   logic            sin_l = 1'b0;
   logic            sin_r = 1'b0;
   logic            start = 1'b0;
   logic [CNTW-1:0] count = '0;
   logic [W-1:0]    q;
   logic            sout_l, sout_r, busy, done;

   univ_shift_reg_shr #(.WIDTH(W), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .sin_l(sin_l), .sin_r(sin_r), .start(start), .count(count),
      .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int q;
      int busy;
      int done;
   } exp_t;

   exp_t exp_fifo[$];

   // Reference model state, in plain integers
   int m_q    = 0;
   int m_left = 0;
   int m_op   = 0;

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int op_val(input int op, input int cur);
      int m;
      m = 1 << W;
      case (op)
         0: return cur;
         1: return int'(d);
         2: return (cur * 2 + int'(sin_r)) % m;
         3: return int'(sin_l) * (m / 2) + cur / 2;
         4: return (cur * 2) % m + cur / (m / 2);
         5: return (cur % 2) * (m / 2) + cur / 2;
         6: return (cur / (m / 2)) * (m / 2) + cur / 2;
         default: return 0;
      endcase
   endfunction

   // Advance the model by one clock using current inputs, queue expectation,
   // then let the edge happen.
   task automatic cyc();
      exp_t e;
      int   nd;
      nd = 0;
      if (rst) begin
         m_q = 0; m_left = 0; m_op = 0;
      end else if (m_left > 0) begin
         m_q = op_val(m_op, m_q);
         m_left--;
         if (m_left == 0) nd = 1;
      end else if (start) begin
         m_op   = int'(mode);
         m_left = int'(count);
         if (m_left == 0) nd = 1;
      end else if (en) begin
         m_q = op_val(int'(mode), m_q);
      end
      e.q = m_q;
      e.busy = (m_left > 0) ? 1 : 0;
      e.done = nd;
      exp_fifo.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Monitor: compares every presented output against the queued expectation
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_fifo.size() > 0) begin
         e = exp_fifo.pop_front();
         cmp("sb_q", int'(q), e.q);
         cmp("sb_busy", int'(busy), e.busy);
         cmp("sb_done", int'(done), e.done);
         cmp("sb_sout_l", int'(sout_l), e.q / (1 << (W - 1)));
         cmp("sb_sout_r", int'(sout_r), e.q % 2);
         cmp("sb_busy_done_excl", int'(busy & done), 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      // Reset dominates a concurrent load
      rst = 1; en = 1; mode = 3'd1; d = 8'hFF;
      cyc();
      cmp("rst_q", int'(q), 8'h00);
      cmp("rst_busy", int'(busy), 0);
      cmp("rst_done", int'(done), 0);
      rst = 0;

      // Single steps
      en = 1; mode = 3'd1; d = 8'hA5; cyc(); cmp("load", int'(q), 8'hA5);
      mode = 3'd2; sin_r = 1; cyc(); cmp("shl", int'(q), 8'h4B);
      mode = 3'd5; cyc(); cmp("ror", int'(q), 8'hA5);
      mode = 3'd6; cyc(); cmp("asr", int'(q), 8'hD2);
      mode = 3'd3; sin_l = 0; cyc(); cmp("shr", int'(q), 8'h69);
      en = 0; mode = 3'd7; cyc(); cmp("hold", int'(q), 8'h69);

      // Burst ROL x3
      en = 1; mode = 3'd1; d = 8'h81; cyc();
      en = 0; start = 1; mode = 3'd4; count = 3; cyc();
      cmp("rol_e0_q", int'(q), 8'h81);
      cmp("rol_e0_busy", int'(busy), 1);
      start = 0; mode = 3'd0;
      cyc(); cmp("rol_e1", int'(q), 8'h03);
      cyc(); cmp("rol_e2", int'(q), 8'h06);
      cyc(); cmp("rol_e3", int'(q), 8'h0C);
      cmp("rol_done", int'(done), 1);
      cmp("rol_busy_end", int'(busy), 0);
      cyc(); cmp("rol_done_clr", int'(done), 0);

      // Zero-count burst
      start = 1; count = 0; mode = 3'd7; cyc();
      cmp("cnt0_q", int'(q), 8'h0C);
      cmp("cnt0_busy", int'(busy), 0);
      cmp("cnt0_done", int'(done), 1);
      start = 0; cyc();
      cmp("cnt0_done_clr", int'(done), 0);

      // SHR burst with interfering inputs
      en = 1; mode = 3'd1; d = 8'hF0; cyc();
      en = 0; start = 1; mode = 3'd3; count = 4; sin_l = 1; cyc();
      for (int i = 0; i < 4; i++) begin
         mode  = 3'(i * 3 + 1);
         en    = (i % 2 == 0);
         start = (i < 3);
         count = 2;
         d     = 8'h00;
         cyc();
      end
      cmp("ign_q", int'(q), 8'hFF);
      cmp("ign_done", int'(done), 1);
      start = 0; en = 0; cyc();
      cmp("ign_no_restart", int'(busy), 0);

      // Back-to-back bursts
      start = 1; mode = 3'd4; count = 1; cyc();
      start = 0; cyc();
      cmp("b2b_done1", int'(done), 1);
      start = 1; mode = 3'd3; count = 2; sin_l = 0; cyc();
      cmp("b2b_busy", int'(busy), 1);
      start = 0; cyc(); cyc();
      cmp("b2b_done2", int'(done), 1);
      cmp("b2b_q", int'(q), 8'h3F);

      // Reset in the middle of a burst
      start = 1; mode = 3'd2; count = 5; cyc();
      start = 0; cyc();
      rst = 1; cyc();
      cmp("midrst_q", int'(q), 0);
      cmp("midrst_busy", int'(busy), 0);
      rst = 0; cyc();
      cmp("midrst_nodone", int'(done), 0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 59) == 0);
         en    = $urandom_range(0, 1);
         mode  = 3'($urandom_range(0, 7));
         d     = 8'($urandom);
         sin_l = $urandom_range(0, 1);
         sin_r = $urandom_range(0, 1);
         start = ($urandom_range(0, 5) == 0);
         count = CNTW'($urandom_range(0, (1 << CNTW) - 1));
         cyc();
      end
      rst = 0; en = 0; start = 0;
      cyc(); cyc();
      cmp("sb_drained", exp_fifo.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
